// File: rtl/mult_div.sv
// Iterative 32-bit multiply/divide unit for the EX stage: shift-add multiply,
// restoring divide, 32 steps per op, sign fix-up on the final step.
module mult_div (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic        hold,
  input  logic        flush,
  output logic        mult_div_done,
  output logic [63:0] mult_div_result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] result_q, result_d;

  logic        req_valid, req_signed, start;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, rem_sh, rem_new;
  logic        rem_ge;
  logic [63:0] step, fixed;

  // MULT/MULTU/DIV/DIVU occupy 0x18..0x1B: bit1 selects divide, bit0 unsigned
  assign req_valid  = (funct[5:2] == 4'b0110);
  assign req_signed = ~funct[0];
  assign start      = (state_q == IDLE) && req_valid && !flush;

  assign abs_a = (req_signed && operand_1[31]) ? -operand_1 : operand_1;
  assign abs_b = (req_signed && operand_2[31]) ? -operand_2 : operand_2;

  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    // Shifted remainder can need 33 bits before the compare/subtract
    rem_sh  = acc_q[63:31];
    rem_ge  = (rem_sh >= {1'b0, opnd_q});
    rem_new = rem_ge ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
    if (is_div_q) begin
      step  = {rem_new[31:0], acc_q[30:0], rem_ge};
      fixed = {(neg_hi_q ? -step[63:32] : step[63:32]),
               (neg_lo_q ? -step[31:0]  : step[31:0])};
    end else begin
      step  = {mul_sum, acc_q[31:1]};
      fixed = neg_lo_q ? -step : step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= 5'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (count_q == 5'd31) state_d = DONE;
        DONE:    if (!hold) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d  = count_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (start) begin
      count_d  = 5'd0;
      is_div_d = funct[1];
      neg_lo_d = req_signed && (operand_1[31] ^ operand_2[31]);
      neg_hi_d = req_signed && funct[1] && operand_1[31];
      opnd_d   = funct[1] ? abs_b : abs_a;
      acc_d    = {32'd0, (funct[1] ? abs_a : abs_b)};
    end else if ((state_q == RUN) && !flush) begin
      count_d = count_q + 5'd1;
      acc_d   = step;
      if (count_q == 5'd31) result_d = fixed;
    end
  end

  always_comb begin
    busy            = (state_q == RUN);
    mult_div_done   = (state_q == DONE);
    mult_div_result = result_q;
  end

endmodule
